pwm_capture: RTL

- Receive-side counterpart of the team's PWM generator: measures an incoming PWM waveform and reports its duty cycle as an integer percentage 0..100.
- Also reports raw period and high time in clk cycles.
- Sits on the board-input side, for example fan tach/PWM feedback or loopback checking of the generator.
- Uses a sequential divider, so a result appears a fixed number of cycles after each completed period.

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_div_seq.sv | 85 ++++++++
 rtl/pwm_capture.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair.
//   state_e   : capture FSM state encoding (WAIT_EDGE, MEASURE)
//   DUTY_MAX  : full-scale duty value in percent
//   num_width : numerator width needed to hold (count * 100)
package pwm_pkg;

  typedef enum logic {
    WAIT_EDGE = 1'b0,
    MEASURE   = 1'b1
  } state_e;

  localparam int DUTY_MAX = 100;

  // Multiplying by 100 needs 7 extra bits (100 < 2^7).
  function automatic int num_width(input int cnt_w);
    return cnt_w + 7;
  endfunction

endpackage

// File: rtl/pwm_div_seq.sv
// Restoring sequential divider, one quotient bit per clock.
// The first bit is resolved on the start edge, so done pulses NUM_W cycles
// after the start cycle. busy stays high through the done cycle.
//   clk, rst_n : clock, async active-low reset
//   i_start    : load i_num / i_den and begin (ignored while busy)
//   i_abort    : drop the division in flight, no done pulse
//   i_num      : dividend, NUM_W bits
//   i_den      : divisor, DEN_W bits (must be non-zero)
//   o_busy     : division in progress or result being presented
//   o_done     : one-cycle pulse, o_quot valid
//   o_quot     : quotient, NUM_W bits
module pwm_div_seq #(
  parameter int NUM_W = 31,
  parameter int DEN_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [NUM_W-1:0] i_num,
  input  logic [DEN_W-1:0] i_den,
  output logic             o_busy,
  output logic             o_done,
  output logic [NUM_W-1:0] o_quot
);

  localparam int STEP_W = $clog2(NUM_W);

  logic [DEN_W-1:0]  r_rem;
  logic [NUM_W-1:0]  r_q;     // dividend bits shift out, quotient bits shift in
  logic [DEN_W-1:0]  r_den;
  logic [STEP_W-1:0] r_steps;
  logic              r_busy;
  logic              r_done;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  function automatic logic [DEN_W+NUM_W-1:0] div_step(
    input logic [DEN_W-1:0] rem,
    input logic [NUM_W-1:0] q,
    input logic [DEN_W-1:0] den
  );
    logic [DEN_W:0] trial;
    logic           fits;
    // NOTE: blocking assignments are correct here; these are function-local
    // temporaries evaluated in order, not clocked state.
    trial = {rem, q[NUM_W-1]};
    fits  = (trial >= {1'b0, den});
    if (fits) trial = trial - {1'b0, den};
    return {trial[DEN_W-1:0], q[NUM_W-2:0], fits};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem   <= '0;
      r_q     <= '0;
      r_den   <= '0;
      r_steps <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start && !o_busy) begin
      {r_rem, r_q} <= div_step('0, i_num, i_den);
      r_den        <= i_den;
      r_steps      <= STEP_W'(NUM_W - 1);
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
    end else if (r_busy) begin
      {r_rem, r_q} <= div_step(r_rem, r_q, r_den);
      r_steps      <= r_steps - STEP_W'(1);
      if (r_steps == STEP_W'(1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_busy = r_busy | r_done;
  assign o_done = r_done;
  assign o_quot = r_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures an incoming PWM waveform: period and high time in clk cycles,
// and duty = floor(high*100/period) clamped to 100.
//   clk, rst_n  : clock, async active-low reset
//   pwm_in      : asynchronous PWM input
//   duty        : last duty in percent (0..100)
//   period      : last period in clk cycles (0 after a timeout)
//   high_time   : last high time in clk cycles (0 after a timeout)
//   duty_valid  : one-cycle pulse when duty/period/high_time update
//   timeout     : input static; cleared by the next measured result
//   overrun     : one-cycle pulse when a period is dropped (divider busy)
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CLOCK_FREQ     = 100_000_000,
  parameter int PWM_FREQ       = 1_000,
  parameter int CNT_W          = 24,
  parameter int TIMEOUT_CYCLES = 2 * CLOCK_FREQ / PWM_FREQ
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [7:0]       duty,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             duty_valid,
  output logic             timeout,
  output logic             overrun
);

  localparam int               NUM_W     = num_width(CNT_W);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TO_LIM    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [7:0]       DUTY_FULL = 8'(DUTY_MAX);

  state_e           r_state, w_state_nxt;
  logic             r_sync1, r_s_q, r_s_d;
  logic [CNT_W-1:0] r_per_cnt, r_hi_cnt, r_wait_cnt;
  logic [CNT_W-1:0] r_p_hold, r_h_hold;
  logic [7:0]       r_duty;
  logic [CNT_W-1:0] r_period, r_high;
  logic             r_valid, r_timeout, r_overrun;

  logic             w_rise, w_capture, w_to_meas, w_to_wait, w_timeout_evt;
  logic             w_start, w_div_busy, w_div_done;
  logic [NUM_W-1:0] w_h_ext, w_num, w_quot;
  logic [7:0]       w_duty_calc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_s_q   <= 1'b0;
      r_s_d   <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_s_q   <= r_sync1;
      r_s_d   <= r_s_q;
    end
  end

  assign w_rise    = r_s_q & ~r_s_d;
  assign w_capture = (r_state == MEASURE) & w_rise;
  // An edge in the limit cycle still counts as a normal capture.
  assign w_to_meas = (r_state == MEASURE) & ~w_rise & (r_per_cnt >= TO_LIM);
  // Static input straight out of reset; only fires once per reset.
  assign w_to_wait = (r_state == WAIT_EDGE) & ~r_timeout & ~w_rise &
                     (r_wait_cnt >= TO_LIM - CNT_ONE);
  assign w_timeout_evt = w_to_meas | w_to_wait;
  assign w_start       = w_capture & ~w_div_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= WAIT_EDGE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives the signal and no
    // latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      WAIT_EDGE: if (w_rise)    w_state_nxt = MEASURE;
      MEASURE:   if (w_to_meas) w_state_nxt = WAIT_EDGE;
      default:                  w_state_nxt = WAIT_EDGE;
    endcase
  end

  // Period / high-time counters; the edge cycle itself counts as high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per_cnt <= '0;
      r_hi_cnt  <= '0;
    end else if (w_rise) begin
      r_per_cnt <= CNT_ONE;
      r_hi_cnt  <= CNT_ONE;
    end else if (r_state == MEASURE && !w_to_meas) begin
      r_per_cnt <= sat_inc(r_per_cnt);
      if (r_s_q) r_hi_cnt <= sat_inc(r_hi_cnt);
    end else begin
      r_per_cnt <= '0;
      r_hi_cnt  <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_wait_cnt <= '0;
    else if (r_state == WAIT_EDGE && !r_timeout)
      r_wait_cnt <= sat_inc(r_wait_cnt);
  end

  // H*100 as shifts and adds: 64 + 32 + 4.
  assign w_h_ext = NUM_W'(r_hi_cnt);
  assign w_num   = (w_h_ext << 6) + (w_h_ext << 5) + (w_h_ext << 2);

  pwm_div_seq #(
    .NUM_W (NUM_W),
    .DEN_W (CNT_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_abort (w_timeout_evt),
    .i_num   (w_num),
    .i_den   (r_per_cnt),
    .o_busy  (w_div_busy),
    .o_done  (w_div_done),
    .o_quot  (w_quot)
  );

  assign w_duty_calc = (w_quot > NUM_W'(DUTY_MAX)) ? DUTY_FULL : w_quot[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_hold  <= '0;
      r_h_hold  <= '0;
      r_duty    <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_overrun <= w_capture & w_div_busy;
      if (w_start) begin
        r_p_hold <= r_per_cnt;
        r_h_hold <= r_hi_cnt;
      end
      if (w_timeout_evt) begin
        r_duty    <= r_s_q ? DUTY_FULL : 8'd0;
        r_period  <= '0;
        r_high    <= '0;
        r_valid   <= 1'b1;
        r_timeout <= 1'b1;
      end else if (w_div_done) begin
        r_duty    <= w_duty_calc;
        r_period  <= r_p_hold;
        r_high    <= r_h_hold;
        r_valid   <= 1'b1;
        r_timeout <= 1'b0;
      end
    end
  end

  assign duty       = r_duty;
  assign period     = r_period;
  assign high_time  = r_high;
  assign duty_valid = r_valid;
  assign timeout    = r_timeout;
  assign overrun    = r_overrun;

endmodule
